// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared edge/center-aligned timebase, shadowed PERIOD/CCR/mode.
// Optional dead-time insertion with complementary outputs when PWM_DT_EN is defined.
module pwm_multi_channel #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NCH      = 4
`ifdef PWM_DT_EN
    ,
    parameter int unsigned DT_WIDTH = 8
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic                 LOAD,
    input  logic                 FORCE_UPD,
    input  logic                 CENTER,
    input  logic [WIDTH-1:0]     PERIOD_IN,
    input  logic [NCH*WIDTH-1:0] CCR_IN,
`ifdef PWM_DT_EN
    input  logic [DT_WIDTH-1:0]  DEADTIME,
    output logic [NCH-1:0]       PWM_OUT_N,
`endif
    output logic [WIDTH-1:0]     CNT,
    output logic                 DIR,
    output logic                 UPDATE,
    output logic [NCH-1:0]       PWM_OUT
);

    logic [WIDTH-1:0]            pre_period;
    logic [WIDTH-1:0]            act_period;
    logic [NCH-1:0][WIDTH-1:0]   pre_ccr;
    logic [NCH-1:0][WIDTH-1:0]   act_ccr;
    logic                        pre_center;
    logic                        act_center;

    logic [WIDTH-1:0]            cnt_nxt;
    logic                        dir_nxt;
    logic                        evt_c;
    logic [NCH-1:0]              ref_c;

    // Timebase next state; evt_c marks the edge where active regs reload
    always_comb begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        evt_c   = 1'b0;
        if (FORCE_UPD || act_period == '0) begin
            evt_c = 1'b1;
        end else if (!act_center) begin
            if (CNT >= act_period) evt_c = 1'b1;
            else                   cnt_nxt = CNT + WIDTH'(1);
        end else if (!DIR) begin
            if (CNT < act_period) begin
                cnt_nxt = CNT + WIDTH'(1);
            end else if (act_period == WIDTH'(1)) begin
                evt_c = 1'b1;
            end else begin
                cnt_nxt = act_period - WIDTH'(1);
                dir_nxt = 1'b1;
            end
        end else begin
            if (CNT <= WIDTH'(1)) begin
                evt_c = 1'b1;
            end else begin
                cnt_nxt = CNT - WIDTH'(1);
                dir_nxt = 1'b1;
            end
        end
    end

    // Per-channel compare reference
    always_comb begin
        ref_c = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!ENABLE || act_ccr[i] == '0) ref_c[i] = 1'b0;
            else if (act_ccr[i] > act_period) ref_c[i] = 1'b1;
            else                               ref_c[i] = (CNT < act_ccr[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_period <= '0;
            pre_ccr    <= '0;
            pre_center <= 1'b0;
            act_period <= '0;
            act_ccr    <= '0;
            act_center <= 1'b0;
            CNT        <= '0;
            DIR        <= 1'b0;
            UPDATE     <= 1'b0;
        end else begin
            if (LOAD) begin
                pre_period <= PERIOD_IN;
                pre_ccr    <= CCR_IN;
                pre_center <= CENTER;
            end
            // Active regs see the preload as it stood before this edge
            if (!ENABLE || evt_c) begin
                act_period <= pre_period;
                act_ccr    <= pre_ccr;
                act_center <= pre_center;
            end
            if (!ENABLE) begin
                CNT    <= '0;
                DIR    <= 1'b0;
                UPDATE <= 1'b0;
            end else begin
                CNT    <= cnt_nxt;
                DIR    <= dir_nxt;
                UPDATE <= evt_c;
            end
        end
    end

`ifdef PWM_DT_EN
    localparam int unsigned RUN_W = DT_WIDTH + 1;

    logic [NCH-1:0]             ref_q;
    logic [NCH-1:0][RUN_W-1:0]  run_q;
    logic [NCH-1:0][RUN_W-1:0]  run_c;

    // Saturating count of consecutive cycles ref has held its current level
    always_comb begin
        run_c = '0;
        for (int i = 0; i < NCH; i++) begin
            run_c[i] = RUN_W'(1);
            if (ref_c[i] == ref_q[i])
                run_c[i] = (&run_q[i]) ? run_q[i] : run_q[i] + RUN_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || !ENABLE) begin
            ref_q     <= '0;
            run_q     <= '0;
            PWM_OUT   <= '0;
            PWM_OUT_N <= '0;
        end else begin
            ref_q <= ref_c;
            run_q <= run_c;
            for (int i = 0; i < NCH; i++) begin
                PWM_OUT[i]   <= ref_c[i]  && (run_c[i] > RUN_W'(DEADTIME));
                PWM_OUT_N[i] <= !ref_c[i] && (run_c[i] > RUN_W'(DEADTIME));
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) PWM_OUT <= '0;
        else     PWM_OUT <= ref_c;
    end
`endif

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed self-checking bench for pwm_multi_channel (covers PWM_DT_EN when defined).
module tb_pwm_multi_channel;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic        force_upd;
    logic        center;
    logic [15:0] period_in;
    logic [63:0] ccr_in;
    logic [15:0] cnt;
    logic        dir;
    logic        update;
    logic [3:0]  pwm_out;
`ifdef PWM_DT_EN
    logic [7:0]  deadtime;
    logic [3:0]  pwm_out_n;
`endif

    int checks = 0;
    int errors = 0;
    int ones;
    int ones_n;
    int overlap;
    int exp_cnt [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    logic [3:0] exp_pwm;
    int c;

    pwm_multi_channel dut (
        .CLK       (clk),
        .RST       (rst),
        .ENABLE    (enable),
        .LOAD      (load),
        .FORCE_UPD (force_upd),
        .CENTER    (center),
        .PERIOD_IN (period_in),
        .CCR_IN    (ccr_in),
`ifdef PWM_DT_EN
        .DEADTIME  (deadtime),
        .PWM_OUT_N (pwm_out_n),
`endif
        .CNT       (cnt),
        .DIR       (dir),
        .UPDATE    (update),
        .PWM_OUT   (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_force;
        load = 1'b1;
        tick();
        load = 1'b0;
        force_upd = 1'b1;
        tick();
        force_upd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; force_upd = 1'b0; center = 1'b0;
        period_in = '0; ccr_in = '0;
`ifdef PWM_DT_EN
        deadtime = 8'd0;
`endif
        tick();
        tick();
        chk("reset_cnt", 32'(cnt), 32'd0);
        chk("reset_dir", 32'(dir), 32'd0);
        chk("reset_upd", 32'(update), 32'd0);
        chk("reset_pwm", 32'(pwm_out), 32'd0);

        // Edge mode, PERIOD=9, CCR={0,3,9,10}
        rst = 1'b0;
        period_in = 16'd9;
        ccr_in = {16'd10, 16'd9, 16'd3, 16'd0};
        load = 1'b1;
        tick();
        load = 1'b0;
        enable = 1'b1;
        force_upd = 1'b1;
        tick();
        force_upd = 1'b0;
        chk("force_cnt", 32'(cnt), 32'd0);
        chk("force_upd", 32'(update), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            c = (k - 1) % 10;
            exp_pwm = {1'b1, c < 9, c < 3, 1'b0};
            chk("edge_cnt", 32'(cnt), 32'(k % 10));
            chk("edge_upd", 32'(update), 32'((k % 10) == 0));
            chk("edge_pwm", 32'(pwm_out), 32'(exp_pwm));
        end

        // Shadow: LOAD CCR1=5 at CNT=4 keeps 3-wide pulse this period
        ones = 0;
        repeat (4) begin tick(); ones += pwm_out[1] ? 1 : 0; end
        chk("shadow_cnt4", 32'(cnt), 32'd4);
        ccr_in[16 +: 16] = 16'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        ones += pwm_out[1] ? 1 : 0;
        repeat (5) begin tick(); ones += pwm_out[1] ? 1 : 0; end
        chk("shadow_wrap_cnt", 32'(cnt), 32'd0);
        chk("shadow_wrap_upd", 32'(update), 32'd1);
        chk("shadow_old_width", 32'(ones), 32'd3);
        ones = 0;
        repeat (10) begin tick(); ones += pwm_out[1] ? 1 : 0; end
        chk("shadow_new_width", 32'(ones), 32'd5);

        // LOAD on the wrap edge applies one period later
        repeat (9) tick();
        chk("same_edge_cnt9", 32'(cnt), 32'd9);
        ccr_in[16 +: 16] = 16'd7;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("same_edge_upd", 32'(update), 32'd1);
        ones = 0;
        repeat (10) begin tick(); ones += pwm_out[1] ? 1 : 0; end
        chk("same_edge_width_old", 32'(ones), 32'd5);
        ones = 0;
        repeat (10) begin tick(); ones += pwm_out[1] ? 1 : 0; end
        chk("same_edge_width_new", 32'(ones), 32'd7);

        // Center mode, PERIOD=8, CCR1=2
        period_in = 16'd8;
        ccr_in = {16'd10, 16'd9, 16'd2, 16'd0};
        center = 1'b1;
        load_force();
        chk("center_force_cnt", 32'(cnt), 32'd0);
        chk("center_force_dir", 32'(dir), 32'd0);
        chk("center_force_upd", 32'(update), 32'd1);
        for (int w = 0; w < 2; w++) begin
            ones = 0;
            for (int j = 0; j < 16; j++) begin
                tick();
                ones += pwm_out[1] ? 1 : 0;
                chk("center_cnt", 32'(cnt), 32'(exp_cnt[j]));
                chk("center_dir", 32'(dir), 32'(j >= 8 && j <= 14));
                chk("center_upd", 32'(update), 32'(j == 15));
            end
            chk("center_width", 32'(ones), 32'd3);
        end

        // PERIOD=0, CCR0=1, edge mode
        period_in = 16'd0;
        ccr_in = {16'd0, 16'd0, 16'd0, 16'd1};
        center = 1'b0;
        load_force();
        repeat (5) begin
            tick();
            chk("p0_cnt", 32'(cnt), 32'd0);
            chk("p0_dir", 32'(dir), 32'd0);
            chk("p0_upd", 32'(update), 32'd1);
            chk("p0_pwm", 32'(pwm_out), 32'h1);
        end

        // ENABLE dropped at CNT=5, then re-enable with new preload
        period_in = 16'd9;
        ccr_in = {16'd10, 16'd9, 16'd3, 16'd0};
        load_force();
        repeat (5) tick();
        chk("en_cnt5", 32'(cnt), 32'd5);
        enable = 1'b0;
        tick();
        chk("dis_cnt", 32'(cnt), 32'd0);
        chk("dis_pwm", 32'(pwm_out), 32'd0);
        chk("dis_upd", 32'(update), 32'd0);
        chk("dis_dir", 32'(dir), 32'd0);
        period_in = 16'd4;
        ccr_in = {16'd0, 16'd0, 16'd2, 16'd0};
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        chk("reen_cnt1", 32'(cnt), 32'd1);
        chk("reen_pwm", 32'(pwm_out), 32'h2);
        repeat (3) tick();
        chk("reen_cnt4", 32'(cnt), 32'd4);
        chk("reen_pwm4", 32'(pwm_out), 32'h0);
        tick();
        chk("reen_wrap_cnt", 32'(cnt), 32'd0);
        chk("reen_wrap_upd", 32'(update), 32'd1);

        // RST mid-period clears outputs and preload
        tick();
        tick();
        chk("pre_rst_cnt", 32'(cnt), 32'd2);
        chk("pre_rst_pwm", 32'(pwm_out), 32'h2);
        rst = 1'b1;
        tick();
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_upd", 32'(update), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_cnt", 32'(cnt), 32'd0);
        chk("post_rst_upd", 32'(update), 32'd1);
        force_upd = 1'b1;
        tick();
        force_upd = 1'b0;
        tick();
        chk("post_rst_force_cnt", 32'(cnt), 32'd0);
        chk("post_rst_force_pwm", 32'(pwm_out), 32'd0);

`ifdef PWM_DT_EN
        // Dead time 2, PERIOD=9, CCR0=5
        deadtime = 8'd2;
        period_in = 16'd9;
        ccr_in = {16'd0, 16'd0, 16'd0, 16'd5};
        load_force();
        repeat (10) tick();
        ones = 0; ones_n = 0; overlap = 0;
        repeat (20) begin
            tick();
            ones    += pwm_out[0] ? 1 : 0;
            ones_n  += pwm_out_n[0] ? 1 : 0;
            overlap += ((pwm_out & pwm_out_n) != 4'h0) ? 1 : 0;
        end
        chk("dt_out_high", 32'(ones), 32'd6);
        chk("dt_outn_high", 32'(ones_n), 32'd6);
        chk("dt_overlap", 32'(overlap), 32'd0);
        ccr_in = {16'd0, 16'd0, 16'd0, 16'd1};
        load_force();
        repeat (10) tick();
        ones = 0; ones_n = 0;
        repeat (20) begin
            tick();
            ones   += pwm_out[0] ? 1 : 0;
            ones_n += pwm_out_n[0] ? 1 : 0;
        end
        chk("dt_short_suppressed", 32'(ones), 32'd0);
        chk("dt_short_outn", 32'(ones_n), 32'd14);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
N-channel PWM generator with one shared timebase counter, shadowed (preloaded) PERIOD/CCR/mode registers and edge- or center-aligned counting. All channels share PERIOD and mode; each channel has its own compare value. Registered outputs drive gate-driver pins directly. It sits between the CPU-side register file, which supplies preload values, and the output pads.

Parameters:
WIDTH, 16, counter / PERIOD / CCR width
NCH, 4, number of PWM channels
DT_WIDTH, 8, dead-time counter width (used only with PWM_DT_EN)

Ports:
CLK  in  1  single clock, all logic rising-edge
RST  in  1  reset, synchronous, active-high
ENABLE  in  1  run enable
LOAD  in  1  capture PERIOD_IN, CCR_IN, CENTER into preload regs this edge
FORCE_UPD  in  1  immediate update event (restart period)
CENTER  in  1  mode to preload: 0 edge-aligned, 1 center-aligned
PERIOD_IN  in  WIDTH  period preload value
CCR_IN  in  NCH*WIDTH  compare preload, channel i at [i*WIDTH +: WIDTH]
CNT  out  WIDTH  current counter value
DIR  out  1  count direction, 0 up, 1 down
UPDATE  out  1  one-cycle pulse: active regs reloaded, visible this cycle
PWM_OUT  out  NCH  PWM outputs

Behaviour:
- Reset (RST=1 at edge): CNT=0, DIR=0, UPDATE=0, PWM_OUT=0; preload and active PERIOD/CCR=0; mode=edge. Reset has priority over everything.
- Preload: at any edge with LOAD=1, preload regs take the inputs, independent of ENABLE. Active regs change only on an update event.
- ENABLE=0: next edge CNT=0, DIR=0, UPDATE=0, PWM_OUT=0; active regs copy preload every cycle.
- Edge mode: CNT counts 0..PERIOD, then wraps to 0. Period is PERIOD+1 cycles. Update event is at the wrap edge. The safety wrap also fires if CNT>PERIOD.
- Center mode: CNT counts up 0..PERIOD with DIR=0, then down to 0 with DIR=1. DIR=1 while CNT goes PERIOD-1..1. DIR=0 when CNT=0 or PERIOD. Period is 2*PERIOD cycles. Update event is the edge where CNT goes 1->0 while counting down.
- PERIOD=0 in either mode: CNT stays 0, DIR=0, update event every cycle.
- Update event: active PERIOD/CCR/mode take the preload value as registered before this edge. A LOAD on the same edge applies at the next event. UPDATE=1 in the cycle CNT==0 following the event.
- FORCE_UPD with ENABLE=1: next edge CNT=0, DIR=0, preload copied to active, UPDATE=1. It overrides normal counting. The same-edge LOAD rule applies.
- Compare rule per channel, ref_i:
  - ENABLE=0 -> 0
  - CCR_i==0 -> 0
  - CCR_i>PERIOD -> 1
  - else CNT<CCR_i
- PWM_OUT_i is ref_i registered: 1-cycle latency from CNT.
- Edge duty = CCR/(PERIOD+1). Center high time = 2*CCR-1 cycles, symmetric about the valley.
- Mode change only at an update event. Counting restarts from CNT=0 in the new mode.

Optional Feature:
PWM_DT_EN:
- Defined: adds ports DEADTIME in DT_WIDTH and PWM_OUT_N out NCH, plus per-channel dead-time counters.
- PWM_OUT_i rises only after ref_i has been 1 for DEADTIME consecutive cycles. PWM_OUT_N_i rises only after ref_i has been 0 for DEADTIME cycles. Either output falls on the cycle after ref_i falls or rises, respectively.
- PWM_OUT_i and PWM_OUT_N_i are never both 1. Pulses shorter than DEADTIME are suppressed.
- DEADTIME=0: PWM_OUT_N = ~PWM_OUT while enabled. Both outputs are 0 on reset or when ENABLE=0.
- Undefined: no DEADTIME or PWM_OUT_N ports; PWM_OUT is the registered ref.

Test Plan:
- Edge mode, PERIOD=9, CCR={0,3,9,10}, LOAD then FORCE_UPD, ENABLE=1 -> CNT 0..9 repeating; ch0 always 0; ch1 high 3 of 10 cycles; ch2 high 9 of 10; ch3 constant 1; UPDATE every 10 cycles with CNT==0; PWM_OUT lags CNT by 1 cycle.
- Shadow: in case 1, LOAD CCR1=5 at CNT=4 -> ch1 stays 3 cycles wide in the current period, 5 cycles from the next; LOAD on the same edge as the wrap applies one period later.
- Center, PERIOD=8, CCR1=2 -> CNT 0,1..8,7..1,0, 16-cycle period; DIR=1 for CNT 7..1 downward; ch1 high 3 cycles (CNT 1,0,1); UPDATE once per 16 cycles at the valley.
- PERIOD=0, CCR0=1, edge mode -> CNT held 0, UPDATE high every cycle, ch0 constant 1.
- ENABLE dropped at CNT=5 -> next edge CNT=0 and PWM_OUT=0. Re-enable restarts at CNT=0 using current preload. RST asserted mid-period -> all outputs 0 at next edge, preload cleared.
- PWM_DT_EN defined, DEADTIME=2, PERIOD=9, CCR0=5 -> PWM_OUT0 high 3 cycles, PWM_OUT_N0 high 3 cycles per period, never overlapping. CCR0=1 -> PWM_OUT0 never high.
